guess_game_ctrl: RTL and testbench
==================================

// Module: guess_game_ctrl
// PURPOSE
//  Number-guessing game controller. Takes debounced keypad events, draws a
//  secret target in 0..99 and scores two-digit guesses against it. Drives the
//  3-bit message code consumed by the text LCD driver.
//  Sits between the keypad scanner (upstream) and the text LCD driver (downstream).
// PARAMETERS
//  MAX_TRIES    7     guesses per game, 1..15
//  HOLD_CYCLES  1000  clk cycles a result message (UP/DOWN/correct/failed) is held, >=1
//  FIXED_TARGET 42    target used when GAME_FIXED_TARGET_EN is defined, 0..99
// PORTS
//  clk            in   1  system clock, all logic on posedge
//  resetn         in   1  asynchronous, active-low reset
//  key_valid      in   1  one-cycle strobe: key_code is valid
//  key_code       in   4  0-9 digit, 4'hA ENTER, 4'hB CLEAR, 4'hC-F ignored
//  output_command out  3  000 correct, 001 failed, 010 UP, 011 DOWN, 100 retry?,
//                         101 game start, 110 enter any number
//  guess          out  7  current accumulated guess, 0..99
//  tries_left     out  4  remaining guesses
//  game_over      out  1  high in S_WIN, S_FAIL and S_RETRY
// BEHAVIOUR
//  Reset (async): state S_START, output_command=101, guess=0, digit count=0,
//   tries_left=MAX_TRIES, game_over=0, hold counter=0, LFSR=8'hA5.
//  Moore FSM; output_command and game_over are registered and change on the
//   same posedge as the state they encode.
//  LFSR: 8-bit maximal-length Fibonacci, taps 8,6,5,4. Free-runs every cycle,
//   never zero. On a new-game draw, v=lfsr[6:0]; target = v<100 ? v : v-100.
//  S_START (101): any key_valid -> draw target, tries_left=MAX_TRIES,
//   guess=0, go S_ENTER.
//  S_ENTER (110):
//   - digit d: if digit count<2 then guess=guess*10+d, count++; else ignored.
//   - CLEAR: guess=0, count=0.
//   - ENTER with count==0: ignored, no try consumed.
//   - ENTER with count>0: tries_left--, then compare:
//     - guess==target: go S_WIN.
//     - mismatch with tries_left now 0: go S_FAIL.
//     - guess<target: go S_UP.
//     - guess>target: go S_DOWN.
//  S_UP (010) / S_DOWN (011): hold HOLD_CYCLES cycles, then go S_ENTER.
//   On exit guess=0 and count=0.
//  S_WIN (000) / S_FAIL (001): hold HOLD_CYCLES cycles, then go S_RETRY.
//  S_RETRY (100): ENTER -> go S_START, guess=0. Other keys ignored.
//  Hold counter: cleared on state entry, exit when counter==HOLD_CYCLES-1.
//   Gives exactly HOLD_CYCLES cycles in the state.
//  key_valid in any hold state is dropped; there is no queueing.
//  key_valid and state exit on the same edge: the key is ignored.
//  Arithmetic: guess*10+d fits in 7 bits because count<=2.
//   Compare is unsigned 7-bit. tries_left never underflows.
//  Reset mid-game: everything returns to reset values and the LFSR reseeds.
// CONFIGURATION
//  GAME_FIXED_TARGET_EN defined: target = FIXED_TARGET on every draw.
//   The LFSR still runs but is unused.
//  GAME_FIXED_TARGET_EN undefined: target is drawn from the LFSR as above.
// TESTING (GAME_FIXED_TARGET_EN, FIXED_TARGET=42, MAX_TRIES=3, HOLD_CYCLES=4)
//  1. Reset release, then key 5 -> output_command 101 -> 110, tries_left=3, guess=0.
//  2. Keys 3,0,ENTER -> guess=30, tries_left=2; 010 held exactly 4 cycles;
//     then 110, guess=0.
//  3. Keys 5,0,ENTER -> 011; then 4,2,ENTER -> 000 for 4 cycles, then 100,
//     game_over=1.
//  4. Keys 9,9,9 -> guess=99 (third digit ignored). Then CLEAR -> guess 0.
//     Then ENTER -> no state change, tries_left unchanged.
//  5. Three wrong guesses -> third ENTER gives 001 (not UP/DOWN), tries_left=0,
//     then 100. Then ENTER -> 101.
//  6. resetn low during S_UP hold -> output_command=101, tries_left=3 immediately.
//     Key during hold -> ignored.

Source files
------------

// File: rtl/guess_game_ctrl.sv
// Number-guessing game controller: draws a 0..99 target, scores two-digit keypad guesses, drives LCD message code.
// Build option: define GAME_FIXED_TARGET_EN to use FIXED_TARGET instead of the LFSR draw.
module guess_game_ctrl #(
  parameter int unsigned MAX_TRIES    = 7,
  parameter int unsigned HOLD_CYCLES  = 1000,
  parameter int unsigned FIXED_TARGET = 42
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [2:0] output_command,
  output logic [6:0] guess,
  output logic [3:0] tries_left,
  output logic       game_over
);

  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [3:0]        TRIES_INIT = 4'(MAX_TRIES);
  localparam logic [7:0]        LFSR_SEED  = 8'hA5;
  localparam logic [3:0]        KEY_ENTER  = 4'hA;
  localparam logic [3:0]        KEY_CLEAR  = 4'hB;

  // State encoding doubles as the LCD message code.
  typedef enum logic [2:0] {
    S_WIN   = 3'b000,
    S_FAIL  = 3'b001,
    S_UP    = 3'b010,
    S_DOWN  = 3'b011,
    S_RETRY = 3'b100,
    S_START = 3'b101,
    S_ENTER = 3'b110
  } state_t;

  state_t            state, state_n;
  logic [6:0]        guess_n;
  logic [1:0]        cnt, cnt_n;
  logic [3:0]        tries_n;
  logic [HOLD_W-1:0] hold_cnt, hold_n;
  logic [7:0]        lfsr;
  logic [6:0]        target, target_n;

  function automatic logic [6:0] draw_target(input logic [6:0] v);
`ifdef GAME_FIXED_TARGET_EN
    draw_target = 7'(FIXED_TARGET);
`else
    draw_target = (v < 7'd100) ? v : v - 7'd100;
`endif
  endfunction

  always_comb begin
    state_n  = state;
    guess_n  = guess;
    cnt_n    = cnt;
    tries_n  = tries_left;
    target_n = target;
    hold_n   = hold_cnt + HOLD_W'(1);
    case (state)
      S_START: begin
        if (key_valid) begin
          target_n = draw_target(lfsr[6:0]);
          tries_n  = TRIES_INIT;
          guess_n  = 7'd0;
          cnt_n    = 2'd0;
          state_n  = S_ENTER;
        end
      end
      S_ENTER: begin
        if (key_valid) begin
          if (key_code <= 4'd9) begin
            if (cnt != 2'd2) begin
              guess_n = guess * 7'd10 + {3'b000, key_code};
              cnt_n   = cnt + 2'd1;
            end
          end else if (key_code == KEY_CLEAR) begin
            guess_n = 7'd0;
            cnt_n   = 2'd0;
          end else if (key_code == KEY_ENTER && cnt != 2'd0) begin
            tries_n = tries_left - 4'd1;
            if (guess == target)     state_n = S_WIN;
            else if (tries_n == 4'd0) state_n = S_FAIL;
            else if (guess < target) state_n = S_UP;
            else                     state_n = S_DOWN;
          end
        end
      end
      S_UP, S_DOWN: begin
        if (hold_cnt == HOLD_LAST) begin
          state_n = S_ENTER;
          guess_n = 7'd0;
          cnt_n   = 2'd0;
        end
      end
      S_WIN, S_FAIL: begin
        if (hold_cnt == HOLD_LAST) state_n = S_RETRY;
      end
      S_RETRY: begin
        if (key_valid && key_code == KEY_ENTER) begin
          state_n = S_START;
          guess_n = 7'd0;
          cnt_n   = 2'd0;
        end
      end
      default: state_n = S_START;
    endcase
    // Every state entry restarts the hold count.
    if (state_n != state) hold_n = '0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_START;
      guess      <= 7'd0;
      cnt        <= 2'd0;
      tries_left <= TRIES_INIT;
      hold_cnt   <= '0;
      lfsr       <= LFSR_SEED;
      game_over  <= 1'b0;
    end else begin
      state      <= state_n;
      guess      <= guess_n;
      cnt        <= cnt_n;
      tries_left <= tries_n;
      hold_cnt   <= hold_n;
      lfsr       <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      game_over  <= (state_n == S_WIN) || (state_n == S_FAIL) || (state_n == S_RETRY);
    end
  end

  // Target is only consulted after a draw, so it carries no reset.
  always_ff @(posedge clk) begin
    target <= target_n;
  end

  assign output_command = state;

endmodule

// File: tb/tb_guess_game_ctrl.sv
// Self-checking bench for guess_game_ctrl against a game-rule reference model (MAX_TRIES=3, HOLD_CYCLES=4).
module tb_guess_game_ctrl;

  localparam int MT   = 3;
  localparam int HOLD = 4;
  localparam int FT   = 42;

  localparam int C_WIN = 0, C_FAIL = 1, C_UP = 2, C_DOWN = 3;
  localparam int C_RETRY = 4, C_START = 5, C_ENTER = 6;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic [2:0] output_command;
  logic [6:0] guess;
  logic [3:0] tries_left;
  logic       game_over;
  logic [14:0] act;

  int n_cmp = 0;
  int n_bad = 0;

  guess_game_ctrl #(.MAX_TRIES(MT), .HOLD_CYCLES(HOLD), .FIXED_TARGET(FT)) dut (
    .clk(clk), .resetn(resetn), .key_valid(key_valid), .key_code(key_code),
    .output_command(output_command), .guess(guess), .tries_left(tries_left),
    .game_over(game_over)
  );

  always #5 clk = ~clk;
  assign act = {output_command, guess, tries_left, game_over};

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got %0d cycles, required fewer", 200000);
    $fatal(1, "timeout");
  end

  // Reference model: game rules tracked with plain integers.
  int         m_cmd, m_guess, m_cnt, m_tries, m_target, m_held;
  logic [7:0] m_lfsr;
  logic [4:0] kq[$];

  function automatic void model_reset();
    m_cmd = C_START; m_guess = 0; m_cnt = 0; m_tries = MT;
    m_held = 0; m_target = 0; m_lfsr = 8'hA5;
  endfunction

  function automatic int draw(input logic [7:0] l);
    int v;
    v = int'(l[6:0]);
`ifdef GAME_FIXED_TARGET_EN
    v = FT;
`endif
    return (v < 100) ? v : v - 100;
  endfunction

  function automatic void model_step(input bit kv, input logic [3:0] kc);
    int nxt;
    nxt = m_cmd;
    case (m_cmd)
      C_START: if (kv) begin
        m_target = draw(m_lfsr); m_tries = MT; m_guess = 0; m_cnt = 0; nxt = C_ENTER;
      end
      C_ENTER: if (kv) begin
        if (kc <= 4'd9) begin
          if (m_cnt < 2) begin m_guess = m_guess * 10 + int'(kc); m_cnt++; end
        end else if (kc == 4'hB) begin
          m_guess = 0; m_cnt = 0;
        end else if (kc == 4'hA && m_cnt > 0) begin
          m_tries--;
          if (m_guess == m_target) nxt = C_WIN;
          else if (m_tries == 0)   nxt = C_FAIL;
          else if (m_guess < m_target) nxt = C_UP;
          else nxt = C_DOWN;
        end
      end
      C_UP, C_DOWN: begin
        m_held++;
        if (m_held == HOLD) begin nxt = C_ENTER; m_guess = 0; m_cnt = 0; end
      end
      C_WIN, C_FAIL: begin
        m_held++;
        if (m_held == HOLD) nxt = C_RETRY;
      end
      C_RETRY: if (kv && kc == 4'hA) begin nxt = C_START; m_guess = 0; m_cnt = 0; end
      default: nxt = C_START;
    endcase
    if (nxt != m_cmd) m_held = 0;
    m_cmd = nxt;
    m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  endfunction

  function automatic logic [14:0] exp_out();
    logic go;
    go = (m_cmd == C_WIN) || (m_cmd == C_FAIL) || (m_cmd == C_RETRY);
    return {3'(m_cmd), 7'(m_guess), 4'(m_tries), go};
  endfunction

  task automatic tick(input bit kv, input logic [3:0] kc);
    key_valid = kv;
    key_code  = kc;
    @(posedge clk);
    model_step(kv, kc);
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  function automatic void push_key(input logic [3:0] k);
    kq.push_back({1'b1, k});
  endfunction

  function automatic void push_idle(input int n);
    for (int i = 0; i < n; i++) kq.push_back(5'd0);
  endfunction

  function automatic void push_num(input int n);
    if (n >= 10) push_key(4'(n / 10));
    push_key(4'(n % 10));
    push_key(4'hA);
  endfunction

  function automatic int wrong_guess();
    int g;
    do g = int'($urandom_range(0, 99)); while (g == m_target);
    return g;
  endfunction

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (act !== 15'b101_0000000_0011_0) begin
      n_bad++; $display("FAIL reset_state: got %h required %h", act, 15'b101_0000000_0011_0);
    end
    n_cmp++;
    if (act !== exp_out()) begin
      n_bad++; $display("FAIL reset_model: got %h required %h", act, exp_out());
    end
  endtask

  task automatic test_start();
    push_key(4'd5); push_idle(2);
    foreach (kq[i]) begin
      tick(kq[i][4], kq[i][3:0]);
      n_cmp++;
      if (act !== exp_out()) begin n_bad++; $display("FAIL start[%0d]: got %h required %h", i, act, exp_out()); end
    end
    kq.delete();
    n_cmp++;
    if (output_command !== 3'b110 || tries_left !== 4'd3 || guess !== 7'd0) begin
      n_bad++; $display("FAIL start_enter: got cmd %b tries %0d guess %0d required 110/3/0", output_command, tries_left, guess);
    end
  endtask

  task automatic test_hints();
    int hc;
    // First hint, with a key landing on the hold-exit edge.
    push_num(wrong_guess()); push_idle(HOLD - 1); push_key(4'd7); push_idle(1);
    push_num(wrong_guess());
    foreach (kq[i]) begin
      tick(kq[i][4], kq[i][3:0]);
      n_cmp++;
      if (act !== exp_out()) begin n_bad++; $display("FAIL hint[%0d]: got %h required %h", i, act, exp_out()); end
    end
    kq.delete();
    hc = 0;
    while ((output_command == 3'b010 || output_command == 3'b011) && hc < 20) begin
      hc++;
      tick(1'b0, 4'd0);
    end
    n_cmp++;
    if (hc !== HOLD || output_command !== 3'b110 || guess !== 7'd0) begin
      n_bad++; $display("FAIL hint_hold: got %0d cycles cmd %b guess %0d required %0d/110/0", hc, output_command, guess, HOLD);
    end
    push_num(m_target); push_idle(HOLD + 1);
    foreach (kq[i]) begin
      tick(kq[i][4], kq[i][3:0]);
      n_cmp++;
      if (act !== exp_out()) begin n_bad++; $display("FAIL win[%0d]: got %h required %h", i, act, exp_out()); end
    end
    kq.delete();
    n_cmp++;
    if (output_command !== 3'b100 || game_over !== 1'b1) begin
      n_bad++; $display("FAIL win_retry: got cmd %b over %b required 100/1", output_command, game_over);
    end
  endtask

  task automatic test_digits();
    push_key(4'hA); push_key(4'd3); push_key(4'd9); push_key(4'd9); push_key(4'd9);
    foreach (kq[i]) begin
      tick(kq[i][4], kq[i][3:0]);
      n_cmp++;
      if (act !== exp_out()) begin n_bad++; $display("FAIL digits[%0d]: got %h required %h", i, act, exp_out()); end
    end
    kq.delete();
    n_cmp++;
    if (guess !== 7'd99) begin n_bad++; $display("FAIL digits_99: got %0d required 99", guess); end
    push_key(4'hB); push_key(4'hA); push_key(4'hE); push_idle(1);
    foreach (kq[i]) begin
      tick(kq[i][4], kq[i][3:0]);
      n_cmp++;
      if (act !== exp_out()) begin n_bad++; $display("FAIL clear[%0d]: got %h required %h", i, act, exp_out()); end
    end
    kq.delete();
    n_cmp++;
    if (output_command !== 3'b110 || tries_left !== 4'd3 || guess !== 7'd0) begin
      n_bad++; $display("FAIL empty_enter: got cmd %b tries %0d guess %0d required 110/3/0", output_command, tries_left, guess);
    end
  endtask

  task automatic test_fail();
    push_num(wrong_guess()); push_idle(HOLD);
    push_num(wrong_guess()); push_idle(HOLD);
    push_num(wrong_guess());
    foreach (kq[i]) begin
      tick(kq[i][4], kq[i][3:0]);
      n_cmp++;
      if (act !== exp_out()) begin n_bad++; $display("FAIL fail[%0d]: got %h required %h", i, act, exp_out()); end
    end
    kq.delete();
    n_cmp++;
    if (output_command !== 3'b001 || tries_left !== 4'd0 || game_over !== 1'b1) begin
      n_bad++; $display("FAIL fail_msg: got cmd %b tries %0d required 001/0", output_command, tries_left);
    end
    push_idle(HOLD); push_key(4'd4); push_key(4'hA);
    foreach (kq[i]) begin
      tick(kq[i][4], kq[i][3:0]);
      n_cmp++;
      if (act !== exp_out()) begin n_bad++; $display("FAIL retry[%0d]: got %h required %h", i, act, exp_out()); end
    end
    kq.delete();
    n_cmp++;
    if (output_command !== 3'b101 || game_over !== 1'b0) begin
      n_bad++; $display("FAIL retry_start: got cmd %b over %b required 101/0", output_command, game_over);
    end
  endtask

  task automatic test_reset_mid();
    push_key(4'd1); push_num(wrong_guess()); push_key(4'd4); push_idle(1);
    foreach (kq[i]) begin
      tick(kq[i][4], kq[i][3:0]);
      n_cmp++;
      if (act !== exp_out()) begin n_bad++; $display("FAIL mid[%0d]: got %h required %h", i, act, exp_out()); end
    end
    kq.delete();
    resetn = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (act !== 15'b101_0000000_0011_0 || act !== exp_out()) begin
      n_bad++; $display("FAIL mid_reset: got %h required %h", act, 15'b101_0000000_0011_0);
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [3:0] kc;
    int r;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end
      r = int'($urandom_range(0, 99));
      if (r < 60)      kc = 4'($urandom_range(0, 9));
      else if (r < 85) kc = 4'hA;
      else if (r < 93) kc = 4'hB;
      else             kc = 4'($urandom_range(12, 15));
      tick(bit'($urandom_range(0, 1)), kc);
      n_cmp++;
      if (act !== exp_out()) begin n_bad++; $display("FAIL random[%0d]: got %h required %h", i, act, exp_out()); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_start();
    test_hints();
    test_digits();
    test_fail();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
